// File: rtl/mac_tx_pkg.sv
// Shared constants and state encoding for the GMII-style frame transmitter.
// Imported by the transmitter top and its CRC helper.
package mac_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    DATA     = 3'd3,
    FCS      = 3'd4,
    IFG      = 3'd5
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned PREAMBLE_LEN  = 7;
  localparam int unsigned FCS_LEN       = 4;
  localparam int unsigned IFG_LEN       = 12;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide step of the reflected IEEE 802.3 CRC-32.
// Bits are consumed LSB first, matching on-wire order.
module crc32_d8
  import mac_tx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data_i[i]) c = (c >> 1) ^ CRC_POLY;
      else                  c = c >> 1;
    end
    crc_o = c;
  end

endmodule

// File: rtl/mac_transmitter.sv
// Frame transmitter: preamble, SFD, payload from show-ahead FIFO,
// CRC-32 FCS and inter-frame gap on a GMII-style byte bus.
module mac_transmitter
  import mac_tx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rd_data,
  input  logic       data_ready,
  input  logic       fifo_empty,
  output logic [2:0] mac_tr_state,
  output logic       rd_en,
  output logic       rd_start,
  output logic       txen,
  output logic [7:0] txd
);

  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       byte_q;
  logic [31:0]      crc_q;
  logic [31:0]      crc_d;
  logic [31:0]      fcs_w;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (rd_data),
    .crc_o  (crc_d)
  );

  assign fcs_w        = ~crc_q;
  assign mac_tr_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      byte_q  <= 8'h00;
      crc_q   <= CRC_INIT;
    end else begin
      if (rd_en) begin
        byte_q <= rd_data;
        crc_q  <= crc_d;
      end
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (data_ready) begin
            state_q <= PREAMBLE;
            crc_q   <= CRC_INIT;
          end
        end
        PREAMBLE: begin
          if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
            state_q <= SFD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SFD: begin
          state_q <= rd_en ? DATA : FCS;
          cnt_q   <= '0;
        end
        DATA: begin
          cnt_q <= '0;
          if (!rd_en) state_q <= FCS;
        end
        FCS: begin
          if (cnt_q == CNT_W'(FCS_LEN - 1)) begin
            state_q <= IFG;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IFG: begin
          if (cnt_q == CNT_W'(IFG_LEN - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Bus outputs come only from registers; rd_data never reaches txd directly
  always_comb begin
    txen     = 1'b0;
    txd      = 8'h00;
    rd_en    = 1'b0;
    rd_start = 1'b0;
    unique case (state_q)
      PREAMBLE: begin
        txen = 1'b1;
        txd  = PREAMBLE_BYTE;
      end
      SFD: begin
        txen     = 1'b1;
        txd      = SFD_BYTE;
        rd_start = 1'b1;
        rd_en    = !fifo_empty;
      end
      DATA: begin
        txen  = 1'b1;
        txd   = byte_q;
        rd_en = !fifo_empty;
      end
      FCS: begin
        txen = 1'b1;
        txd  = fcs_w[{cnt_q[1:0], 3'b000} +: 8];
      end
      default: begin
        txen = 1'b0;
        txd  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_transmitter.sv
// Directed bench for mac_transmitter with an expected-byte scoreboard
// and an MSB-first CRC-32 reference model.
module tb_mac_transmitter;

  localparam int S_IDLE = 0;
  localparam int S_PRE  = 1;
  localparam int S_DATA = 3;
  localparam int S_IFG  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       data_ready = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [2:0] mac_tr_state;
  logic       rd_en;
  logic       rd_start;
  logic       txen;
  logic [7:0] txd;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] payload[$];

  mac_transmitter dut (
    .clk          (clk),
    .reset        (reset),
    .rd_data      (rd_data),
    .data_ready   (data_ready),
    .fifo_empty   (fifo_empty),
    .mac_tr_state (mac_tr_state),
    .rd_en        (rd_en),
    .rd_start     (rd_start),
    .txen         (txen),
    .txd          (txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_upd();
    fifo_empty = (fifo_q.size() == 0);
    rd_data    = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  // Non-reflected MSB-first form with poly 0x04C11DB7, reflected at the end
  function automatic logic [31:0] crc_model();
    logic [31:0] c;
    logic [31:0] r;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (payload[j]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[31] ^ payload[j][i];
        c  = c << 1;
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return ~r;
  endfunction

  task automatic run_frame(input string name, input bit hold, input bit poke);
    logic [31:0] fcs;
    int ntx, nrd, nst, nifg, total;
    bit done, pd, pi, pop;
    ntx = 0; nrd = 0; nst = 0; nifg = 0;
    done = 0; pd = 0; pi = 0;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (payload[j]) exp_q.push_back(payload[j]);
    fcs = crc_model();
    for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    total = exp_q.size();
    fifo_q = payload;
    fifo_upd();
    data_ready = 1'b1;
    @(posedge clk); #1;
    if (!hold) data_ready = 1'b0;
    chk({name, " start"}, 32'(mac_tr_state), S_PRE);
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (mac_tr_state == S_IDLE && ntx > 0) begin
        done = 1;
      end else begin
        if (txen) begin
          ntx++;
          if (exp_q.size() > 0) chk({name, " txd"}, 32'(txd), 32'(exp_q.pop_front()));
          else chk({name, " overrun"}, ntx, total);
        end else begin
          chk({name, " idle txd"}, 32'(txd), 0);
        end
        if (rd_en) nrd++;
        if (rd_start) nst++;
        if (mac_tr_state == S_IFG) nifg++;
        if (poke && !pd && mac_tr_state == S_DATA) begin
          data_ready = 1'b1; pd = 1;
        end else if (poke && !pi && mac_tr_state == S_IFG) begin
          data_ready = 1'b1; pi = 1;
        end else if (!hold) begin
          data_ready = 1'b0;
        end
        pop = rd_en;
        @(posedge clk); #1;
        if (pop) begin
          void'(fifo_q.pop_front());
          fifo_upd();
        end
      end
    end
    chk({name, " done"}, 32'(done), 1);
    chk({name, " txen cycles"}, ntx, total);
    chk({name, " rd_en cycles"}, nrd, payload.size());
    chk({name, " rd_start"}, nst, 1);
    chk({name, " ifg cycles"}, nifg, 12);
    chk({name, " sb empty"}, exp_q.size(), 0);
    if (poke) chk({name, " poked"}, 32'({pd, pi}), 3);
  endtask

  initial begin
    bit hit;
    fifo_upd();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst state", 32'(mac_tr_state), 0);
    chk("rst txen", 32'(txen), 0);
    chk("rst txd", 32'(txd), 0);
    chk("rst rd_en", 32'(rd_en), 0);
    chk("rst rd_start", 32'(rd_start), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("no start w/o req", 32'(mac_tr_state), 0);

    payload = '{8'hAB, 8'hCD, 8'hEF};
    run_frame("f1", 1'b1, 1'b0);
    payload = '{8'hAB, 8'hCD, 8'hEF, 8'hAB};
    run_frame("f2", 1'b0, 1'b0);
    payload.delete();
    run_frame("empty", 1'b0, 1'b0);
    payload = '{8'h11, 8'h22, 8'h33};
    run_frame("poke", 1'b0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("poke no extra", 32'({mac_tr_state, txen}), 0);
    end

    payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    fifo_q = payload;
    fifo_upd();
    data_ready = 1'b1;
    @(posedge clk); #1;
    data_ready = 1'b0;
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (mac_tr_state == S_DATA) begin
        hit = 1;
      end else begin
        bit pop;
        pop = rd_en;
        @(posedge clk); #1;
        if (pop) begin
          void'(fifo_q.pop_front());
          fifo_upd();
        end
      end
    end
    chk("reached data", 32'(hit), 1);
    reset = 1'b0;
    #1;
    chk("abort txen", 32'(txen), 0);
    chk("abort state", 32'(mac_tr_state), 0);
    chk("abort txd", 32'(txd), 0);
    chk("abort rd_en", 32'(rd_en), 0);
    fifo_q.delete();
    fifo_upd();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post rst idle", 32'({mac_tr_state, txen}), 0);
    end

    payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_frame("after rst", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_transmitter.md
MAC_TRANSMITTER -- requirements
Module: mac_transmitter

Interface
REQ-001 The module SHALL have exactly one clock, `clk` (input, 1 bit); all state updates occur on its rising edge.
REQ-002 The module SHALL have one reset, `reset` (input, 1 bit), which is asynchronous and active-low.
REQ-003 `rd_data` SHALL be an input, 8 bits: the head byte of a show-ahead transmit FIFO, valid in the same cycle as `rd_en`.
REQ-004 `data_ready` SHALL be an input, 1 bit: a frame is queued; it is sampled only in IDLE.
REQ-005 `fifo_empty` SHALL be an input, 1 bit: the FIFO holds no further payload bytes.
REQ-006 `mac_tr_state` SHALL be an output, 3 bits, equal to the current state encoding.
REQ-007 `rd_en` SHALL be an output, 1 bit: pops one byte from the FIFO in the cycle it is high.
REQ-008 `rd_start` SHALL be an output, 1 bit: a one-cycle frame-read start marker to the FIFO.
REQ-009 `txen` SHALL be an output, 1 bit: transmit enable on the GMII-style byte bus.
REQ-010 `txd` SHALL be an output, 8 bits: transmit data, meaningful only while `txen` is 1.

Function
REQ-011 The state machine SHALL use these encodings: IDLE=0, PREAMBLE=1, SFD=2, DATA=3, FCS=4, IFG=5; codes 6 and 7 SHALL transition to IDLE.
REQ-012 In IDLE, a rising edge with `data_ready`=1 SHALL move the state to PREAMBLE and clear the cycle counter; in any other state, `data_ready` SHALL be ignored.
REQ-013 PREAMBLE SHALL last exactly 7 cycles with `txen`=1 and `txd`=0x55, then move to SFD.
REQ-014 SFD SHALL last 1 cycle with `txen`=1 and `txd`=0xD5; `rd_start`=1 only in this cycle.
REQ-015 `rd_en` SHALL equal !`fifo_empty` in SFD and DATA and SHALL be 0 in all other states; it is combinational.
REQ-016 On each edge where `rd_en`=1, the byte register SHALL load `rd_data` and the CRC SHALL be updated with that byte.
REQ-017 From SFD, the next state SHALL be DATA if `rd_en`=1, else FCS, which covers the empty-payload case.
REQ-018 In DATA, `txen`=1 and `txd` SHALL equal the byte register; the state SHALL remain DATA while `rd_en`=1 and move to FCS on the first edge with `rd_en`=0.
REQ-019 Each payload byte SHALL appear on `txd` exactly one cycle after the cycle in which it was popped, in FIFO order, with no gaps, duplication or padding.
REQ-020 FCS SHALL last 4 cycles with `txen`=1, sending the complemented CRC-32 low byte first.
REQ-021 The CRC SHALL be IEEE 802.3 CRC-32: reflected, polynomial 0xEDB88320, initial value 0xFFFFFFFF, final complement, computed over payload bytes only.
REQ-022 IFG SHALL last 12 cycles with `txen`=0, then the state SHALL move to IDLE; IDLE and IFG SHALL drive `txd`=0x00.
REQ-023 The CRC register SHALL reinitialise to 0xFFFFFFFF on entry to PREAMBLE.
REQ-024 There SHALL be no maximum frame length.
REQ-025 A `fifo_empty` rise mid-frame SHALL end the payload.
REQ-026 `txen`, `txd`, `rd_en` and `rd_start` SHALL be decoded from registered state, counter and byte register only (`rd_en` additionally uses `fifo_empty`), with no combinational path from `rd_data` to `txd`.

Reset
REQ-027 While `reset`=0: state=IDLE, counter=0, byte register=0x00, CRC=0xFFFFFFFF, `txen`=0, `txd`=0x00, `rd_en`=0, `rd_start`=0, `mac_tr_state`=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), with no FCS and no IFG.
REQ-029 After reset deassertion, the first frame SHALL require a fresh `data_ready`.

Structure
REQ-030 Package mac_tx_pkg SHALL hold the state enum, PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, PREAMBLE_LEN=7, FCS_LEN=4, IFG_LEN=12 and CRC_POLY=0xEDB88320.
REQ-031 One combinational sub-module, crc32_d8, SHALL compute the next CRC from the current CRC and 8 data bits.

Verification
REQ-032 Reset: hold `reset`=0 for 1 cycle -> all outputs 0 and `mac_tr_state`=0.
REQ-033 Three-byte frame: pulse `data_ready`; FIFO supplies AB, CD, EF, then `fifo_empty`=1 -> `txd` sequence 55x7, D5, AB, CD, EF, then the 4 CRC-32 bytes of {AB,CD,EF}, LSB first; `txen` high for exactly 15 cycles; `rd_start` 1 pulse; exactly 3 `rd_en` cycles; then IFG 12 cycles, then IDLE.
REQ-034 Back-to-back frames: after frame 1, send a 4-byte frame AB, CD, EF, AB -> second frame starts only after 12 IFG cycles; `txen` high 16 cycles; FCS matches the model.
REQ-035 Empty payload: `fifo_empty`=1 at `data_ready` -> 55x7, D5, 00 00 00 00; zero `rd_en` cycles.
REQ-036 Ignored request: `data_ready` pulsed during DATA and IFG -> no extra frame and no state disturbance.
REQ-037 Mid-frame reset: assert `reset`=0 during DATA -> `txen`=0 immediately; state IDLE; the next frame is correct.
